// File: rtl/pw_requant_writeback.sv
// pw_requant_writeback: requantises 16 lanes of int32 partial sums to int8 and writes packed 128-bit words.
// Latency: y_valid in cycle N -> feat_wr_en in N+3; one word per cycle sustained.
// Backpressure: feat_wr_ready low holds the output reg, then S1, then a 2-entry FIFO; a push to a full FIFO is dropped and sets overflow.
// Ports: CLK/RESET (sync, active-high); start + out_base/word_total/shift_amt/zero_point (config, latched on start);
//        y_valid/y_data/y_tile_sel (result pulses, no ready); feat_wr_en/addr/data/bank/ready (write port);
//        busy, done (1-cycle pulse), overflow (sticky until next start).
// Build option: define PW_WB_RELU_EN to clamp negative post-shift values to 0 before the zero-point add.

// Two-entry FIFO; a push while full is accepted only when a pop happens in the same cycle.
module pw_wb_fifo2 #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && (!full || pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, pop};
    end
  end
endmodule

module pw_requant_writeback #(
  parameter int NUM_COLS = 16,
  parameter int ACC_BITS = 32,
  parameter int OUT_BITS = 8,
  parameter int ADDR_W   = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            out_base,
  input  logic [15:0]                  word_total,
  input  logic [4:0]                   shift_amt,
  input  logic [7:0]                   zero_point,
  input  logic                         y_valid,
  input  logic [NUM_COLS*ACC_BITS-1:0] y_data,
  input  logic                         y_tile_sel,
  output logic                         feat_wr_en,
  output logic [ADDR_W-1:0]            feat_wr_addr,
  output logic [NUM_COLS*OUT_BITS-1:0] feat_wr_data,
  output logic                         feat_wr_bank,
  input  logic                         feat_wr_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);
  localparam int DW = NUM_COLS * ACC_BITS;
  localparam logic signed [ACC_BITS+1:0] SAT_MAX =
    $signed({{(ACC_BITS+3-OUT_BITS){1'b0}}, {(OUT_BITS-1){1'b1}}});
  localparam logic signed [ACC_BITS+1:0] SAT_MIN =
    $signed({{(ACC_BITS+3-OUT_BITS){1'b1}}, {(OUT_BITS-1){1'b0}}});

  // Round-half-up arithmetic shift; the +half is done in ACC_BITS+1 bits so it cannot wrap.
  function automatic logic [ACC_BITS-1:0] round_shift(input logic [ACC_BITS-1:0] acc,
                                                      input logic [4:0] sh);
    logic signed [ACC_BITS:0] half;
    logic signed [ACC_BITS:0] sum;
    half = {{ACC_BITS{1'b0}}, 1'b1} << (sh - 5'd1);
    sum  = $signed({acc[ACC_BITS-1], acc}) + half;
    sum  = sum >>> sh;
    return (sh == 5'd0) ? acc : sum[ACC_BITS-1:0];
  endfunction

  // Optional ReLU, zero-point add in ACC_BITS+2 bits, saturate to the signed output range.
  function automatic logic [OUT_BITS-1:0] requant(input logic [ACC_BITS-1:0] v_in,
                                                  input logic [7:0] zp);
    logic [ACC_BITS-1:0]        v;
    logic signed [ACC_BITS+1:0] w;
    logic [OUT_BITS-1:0]        res;
    v = v_in;
`ifdef PW_WB_RELU_EN
    if (v[ACC_BITS-1]) v = '0;
`endif
    w = $signed({{2{v[ACC_BITS-1]}}, v}) + $signed({{(ACC_BITS+2-8){zp[7]}}, zp});
    if (w > SAT_MAX)      res = SAT_MAX[OUT_BITS-1:0];
    else if (w < SAT_MIN) res = SAT_MIN[OUT_BITS-1:0];
    else                  res = w[OUT_BITS-1:0];
    return res;
  endfunction

  logic [ADDR_W-1:0]   base_q;
  logic [15:0]         total_q;
  logic [4:0]          shift_q;
  logic [7:0]          zp_q;
  logic [15:0]         word_idx;
  logic [ADDR_W-1:0]   load_addr;   // address of the next word entering the output register
  logic                s1_vld;
  logic                s1_bank;
  logic [ACC_BITS-1:0] s1_v [NUM_COLS];

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_flush;
  logic [DW:0]   fifo_rdata;
  logic          xfer, out_ld, last_xfer;

  assign xfer       = feat_wr_en && feat_wr_ready;
  assign out_ld     = s1_vld && (!feat_wr_en || xfer);
  assign fifo_pop   = !fifo_empty && (!s1_vld || out_ld);
  assign fifo_push  = y_valid && busy && !start;
  assign last_xfer  = xfer && ((word_idx + 16'd1) == total_q);
  // Completing the run also discards any surplus words so they never reach the sink.
  assign fifo_flush = start || last_xfer;

  pw_wb_fifo2 #(.W(DW + 1)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({y_data, y_tile_sel}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // S1 data: no reset needed, qualified by s1_vld.
  always_ff @(posedge CLK) begin
    if (fifo_pop) begin
      s1_bank <= fifo_rdata[0];
      for (int i = 0; i < NUM_COLS; i++)
        s1_v[i] <= round_shift(fifo_rdata[1 + i*ACC_BITS +: ACC_BITS], shift_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      base_q       <= '0;
      total_q      <= '0;
      shift_q      <= '0;
      zp_q         <= '0;
      word_idx     <= '0;
      load_addr    <= '0;
      s1_vld       <= 1'b0;
      feat_wr_en   <= 1'b0;
      feat_wr_addr <= '0;
      feat_wr_data <= '0;
      feat_wr_bank <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else if (start) begin
      base_q     <= out_base;
      total_q    <= word_total;
      shift_q    <= shift_amt;
      zp_q       <= zero_point;
      word_idx   <= '0;
      load_addr  <= out_base;
      s1_vld     <= 1'b0;
      feat_wr_en <= 1'b0;
      overflow   <= 1'b0;
      busy       <= (word_total != 16'd0);
      done       <= (word_total == 16'd0);
    end else begin
      done <= 1'b0;
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;

      if (fifo_pop)    s1_vld <= 1'b1;
      else if (out_ld) s1_vld <= 1'b0;

      if (out_ld) begin
        feat_wr_en   <= 1'b1;
        feat_wr_addr <= load_addr;
        feat_wr_bank <= s1_bank;
        for (int i = 0; i < NUM_COLS; i++)
          feat_wr_data[i*OUT_BITS +: OUT_BITS] <= requant(s1_v[i], zp_q);
        load_addr <= load_addr + ADDR_W'(1);
      end else if (xfer) begin
        feat_wr_en <= 1'b0;
      end

      if (xfer) word_idx <= word_idx + 16'd1;

      if (last_xfer) begin
        busy       <= 1'b0;
        done       <= 1'b1;
        s1_vld     <= 1'b0;
        feat_wr_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pw_requant_writeback.sv
// Bench for pw_requant_writeback: directed cases plus randomized runs against a
// reference model of the requantisation rules and write ordering.
module tb_pw_requant_writeback;
  localparam int NC = 16;
  localparam int AB = 32;
  localparam int AW = 16;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              start;
  logic [AW-1:0]     out_base;
  logic [15:0]       word_total;
  logic [4:0]        shift_amt;
  logic [7:0]        zero_point;
  logic              y_valid;
  logic [NC*AB-1:0]  y_data;
  logic              y_tile_sel;
  logic              feat_wr_en;
  logic [AW-1:0]     feat_wr_addr;
  logic [127:0]      feat_wr_data;
  logic              feat_wr_bank;
  logic              feat_wr_ready;
  logic              busy;
  logic              done;
  logic              overflow;

  pw_requant_writeback dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .start         (start),
    .out_base      (out_base),
    .word_total    (word_total),
    .shift_amt     (shift_amt),
    .zero_point    (zero_point),
    .y_valid       (y_valid),
    .y_data        (y_data),
    .y_tile_sel    (y_tile_sel),
    .feat_wr_en    (feat_wr_en),
    .feat_wr_addr  (feat_wr_addr),
    .feat_wr_data  (feat_wr_data),
    .feat_wr_bank  (feat_wr_bank),
    .feat_wr_ready (feat_wr_ready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [127:0]  dat;
    logic          bank;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  wr_t           hold;
  bit            holding = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc_cnt = 0;
  int            xfer_cnt = 0;
  int            last_xfer_cyc = -10;
  int            m_sh;
  int            m_zp;
  logic [AW-1:0] m_addr;

  always @(posedge CLK) cyc_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Reference: round-half-up shift, optional ReLU, zero-point add, clamp to int8.
  function automatic logic [7:0] ref_byte(input int acc, input int sh, input int zp);
    longint v;
    longint w;
    v = acc;
    if (sh != 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
`ifdef PW_WB_RELU_EN
    if (v < 0) v = 0;
`endif
    w = v + zp;
    if (w > 127)  w = 127;
    if (w < -128) w = -128;
    return w[7:0];
  endfunction

  function automatic logic [NC*AB-1:0] rand_word(input int sh);
    logic [NC*AB-1:0] d;
    for (int i = 0; i < NC; i++) begin
      int lane;
      case ($urandom_range(0, 3))
        0:       lane = int'($urandom);
        1:       lane = (int'($urandom_range(0, 511)) - 256) * (1 << sh);
        2:       lane = int'($urandom_range(0, 300)) - 150;
        default: lane = (int'($urandom_range(0, 63)) - 32) * (1 << sh)
                        + ((sh == 0) ? 0 : (1 << (sh - 1))) - int'($urandom_range(0, 1));
      endcase
      d[i*AB +: AB] = lane;
    end
    return d;
  endfunction

  task automatic push_exp(input logic [NC*AB-1:0] d, input logic bank);
    wr_t e;
    e.addr = m_addr;
    e.bank = bank;
    e.dat  = '0;
    for (int i = 0; i < NC; i++)
      e.dat[i*8 +: 8] = ref_byte($signed(d[i*AB +: AB]), m_sh, m_zp);
    exp_q.push_back(e);
    m_addr = m_addr + 16'd1;
  endtask

  task automatic do_start(input logic [15:0] base, input logic [15:0] total,
                          input logic [4:0] sh, input logic [7:0] zp);
    start      = 1'b1;
    out_base   = base;
    word_total = total;
    shift_amt  = sh;
    zero_point = zp;
    exp_q.delete();
    m_addr = base;
    m_sh   = int'(sh);
    m_zp   = int'($signed(zp));
    cyc();
    start      = 1'b0;
    // Scribble config afterwards: only the latched copy may matter.
    out_base   = 16'($urandom);
    word_total = 16'($urandom);
    shift_amt  = 5'($urandom);
    zero_point = 8'($urandom);
  endtask

  task automatic drive_word(input logic [NC*AB-1:0] d, input logic bank, input bit accept);
    y_valid    = 1'b1;
    y_data     = d;
    y_tile_sel = bank;
    if (accept) push_exp(d, bank);
    cyc();
    y_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (!done && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_done"}, 128'(done), 128'(1));
    if (done) begin
      chk({tag, "_gap"}, 128'(cyc_cnt - last_xfer_cyc), 128'(1));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
    end
    cyc();
  endtask

  // One word through an idle pipeline with an always-ready sink.
  task automatic run_single(input logic [4:0] sh, input logic [7:0] zp,
                            input logic [127:0] lanes03, input logic [31:0] exp_lo,
                            input string tag);
    logic [NC*AB-1:0] d;
    feat_wr_ready = 1'b1;
    do_start(16'h0010, 16'd1, sh, zp);
    @(negedge CLK);
    chk({tag, "_busy_on"}, 128'(busy), 128'(1));
    cyc();
    d = rand_word(int'(sh));
    d[127:0] = lanes03;
    drive_word(d, 1'b0, 1'b1);
    @(negedge CLK);
    chk({tag, "_en_n1"}, 128'(feat_wr_en), 128'(0));
    cyc();
    @(negedge CLK);
    chk({tag, "_en_n2"}, 128'(feat_wr_en), 128'(0));
    cyc();
    @(negedge CLK);
    chk({tag, "_en_n3"}, 128'(feat_wr_en), 128'(1));
    chk({tag, "_bytes"}, 128'(feat_wr_data[31:0]), 128'(exp_lo));
    wait_done(10, tag);
  endtask

  // Write monitor: scoreboard compare on transfers, stability while stalled.
  always @(negedge CLK) begin
    if (holding && feat_wr_en) begin
      chk("hold_addr", 128'(feat_wr_addr), 128'(hold.addr));
      chk("hold_dat", feat_wr_data, hold.dat);
      chk("hold_bank", 128'(feat_wr_bank), 128'(hold.bank));
    end
    if (feat_wr_en && feat_wr_ready) begin
      xfer_cnt++;
      last_xfer_cyc = cyc_cnt;
      holding = 1'b0;
      chk("wr_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 128'(feat_wr_addr), 128'(mon_e.addr));
        chk("wr_data", feat_wr_data, mon_e.dat);
        chk("wr_bank", 128'(feat_wr_bank), 128'(mon_e.bank));
      end
    end else if (feat_wr_en) begin
      if (!holding) begin
        hold.addr = feat_wr_addr;
        hold.dat  = feat_wr_data;
        hold.bank = feat_wr_bank;
        holding   = 1'b1;
      end
    end else begin
      holding = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    RESET = 1'b1; start = 1'b0; out_base = '0; word_total = '0; shift_amt = '0;
    zero_point = '0; y_valid = 1'b0; y_data = '0; y_tile_sel = 1'b0; feat_wr_ready = 1'b1;
    m_sh = 0; m_zp = 0; m_addr = '0;
    repeat (3) cyc();
    @(negedge CLK);
    chk("rst_en", 128'(feat_wr_en), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_bank", 128'(feat_wr_bank), 128'(0));
    chk("rst_addr", 128'(feat_wr_addr), 128'(0));
    chk("rst_data", feat_wr_data, 128'(0));
    cyc();
    RESET = 1'b0;
    cyc();

    // Passthrough and saturation: 5, -3, 200, -200.
`ifdef PW_WB_RELU_EN
    run_single(5'd0, 8'd0, {32'hFFFF_FF38, 32'd200, 32'hFFFF_FFFD, 32'd5}, 32'h007F_0005, "pass");
`else
    run_single(5'd0, 8'd0, {32'hFFFF_FF38, 32'd200, 32'hFFFF_FFFD, 32'd5}, 32'h807F_FD05, "pass");
`endif
    // Rounding and zero-point: shift 4, zp +10, lanes 24, -24, 8, -9.
`ifdef PW_WB_RELU_EN
    run_single(5'd4, 8'd10, {32'hFFFF_FFF7, 32'd8, 32'hFFFF_FFE8, 32'd24}, 32'h0A0B_0A0C, "round");
`else
    run_single(5'd4, 8'd10, {32'hFFFF_FFF7, 32'd8, 32'hFFFF_FFE8, 32'd24}, 32'h090B_090C, "round");
`endif
    // Negative zero-point: lanes -3, 7, zp -5 (lanes 2,3 = 0 -> -5).
`ifdef PW_WB_RELU_EN
    run_single(5'd0, 8'hFB, {32'd0, 32'd0, 32'd7, 32'hFFFF_FFFD}, 32'hFBFB_02FB, "relu");
`else
    run_single(5'd0, 8'hFB, {32'd0, 32'd0, 32'd7, 32'hFFFF_FFFD}, 32'hFBFB_02F8, "relu");
`endif

    // Stalled sink: 6 back-to-back pulses, only 4 fit.
    feat_wr_ready = 1'b0;
    do_start(16'h0100, 16'd4, 5'($urandom), 8'($urandom));
    x0 = xfer_cnt;
    for (int i = 0; i < 6; i++) drive_word(rand_word(m_sh), 1'($urandom), i < 4);
    repeat (2) cyc();
    @(negedge CLK);
    chk("ovf_set", 128'(overflow), 128'(1));
    chk("ovf_stall_en", 128'(feat_wr_en), 128'(1));
    chk("ovf_no_xfer", 128'(xfer_cnt - x0), 128'(0));
    cyc();
    feat_wr_ready = 1'b1;
    wait_done(20, "ovf");
    chk("ovf_xfers", 128'(xfer_cnt - x0), 128'(4));

    // Address wrap and bank tagging; late pulse after done is ignored.
    do_start(16'hFFFF, 16'd3, 5'($urandom), 8'($urandom));
    x0 = xfer_cnt;
    drive_word(rand_word(m_sh), 1'b1, 1'b1);
    drive_word(rand_word(m_sh), 1'b0, 1'b1);
    drive_word(rand_word(m_sh), 1'b1, 1'b1);
    wait_done(20, "addr");
    @(negedge CLK);
    chk("addr_done_pulse", 128'(done), 128'(0));
    cyc();
    drive_word(rand_word(m_sh), 1'b1, 1'b0);
    repeat (6) cyc();
    chk("late_ignored", 128'(xfer_cnt - x0), 128'(3));

    // RESET with 2 words pending.
    feat_wr_ready = 1'b0;
    do_start(16'h0200, 16'd5, 5'($urandom), 8'($urandom));
    drive_word(rand_word(m_sh), 1'b1, 1'b1);
    drive_word(rand_word(m_sh), 1'b1, 1'b1);
    repeat (4) cyc();
    RESET = 1'b1;
    exp_q.delete();
    x0 = xfer_cnt;
    cyc();
    @(negedge CLK);
    chk("mrst_en", 128'(feat_wr_en), 128'(0));
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_done", 128'(done), 128'(0));
    chk("mrst_ovf", 128'(overflow), 128'(0));
    chk("mrst_bank", 128'(feat_wr_bank), 128'(0));
    chk("mrst_addr", 128'(feat_wr_addr), 128'(0));
    chk("mrst_data", feat_wr_data, 128'(0));
    cyc();
    RESET = 1'b0;
    feat_wr_ready = 1'b1;
    repeat (8) cyc();
    chk("mrst_no_wr", 128'(xfer_cnt - x0), 128'(0));

    // Abort by start (word_total 0) with a full pipeline and overflow set.
    feat_wr_ready = 1'b0;
    do_start(16'h0300, 16'd5, 5'($urandom), 8'($urandom));
    for (int i = 0; i < 6; i++) drive_word(rand_word(m_sh), 1'($urandom), i < 4);
    repeat (2) cyc();
    @(negedge CLK);
    chk("abort_ovf_pre", 128'(overflow), 128'(1));
    cyc();
    x0 = xfer_cnt;
    do_start(16'h0055, 16'd0, 5'd0, 8'd0);
    @(negedge CLK);
    chk("abort_done", 128'(done), 128'(1));
    chk("abort_en", 128'(feat_wr_en), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_ovf", 128'(overflow), 128'(0));
    cyc();
    feat_wr_ready = 1'b1;
    repeat (6) cyc();
    chk("abort_no_wr", 128'(xfer_cnt - x0), 128'(0));

    // Randomized runs; run 0 streams every cycle into an always-ready sink.
    for (int r = 0; r < 4; r++) begin
      int sent;
      int guard;
      sent = 0;
      guard = 0;
      do_start(16'($urandom), 16'd40, 5'($urandom), 8'($urandom));
      x0 = xfer_cnt;
      while (sent < 40 && guard < 2000) begin
        feat_wr_ready = (r == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if ((sent - (xfer_cnt - x0)) < 4 && (r == 0 || $urandom_range(0, 2) != 0)) begin
          y_valid    = 1'b1;
          y_data     = rand_word(m_sh);
          y_tile_sel = 1'($urandom);
          push_exp(y_data, y_tile_sel);
          sent++;
        end else begin
          y_valid = 1'b0;
        end
        cyc();
        guard++;
      end
      y_valid = 1'b0;
      if (r == 0) chk("rnd_throughput", 128'(guard), 128'(40));
      feat_wr_ready = 1'b1;
      wait_done(200, "rnd");
      chk("rnd_drained", 128'(exp_q.size()), 128'(0));
      chk("rnd_no_ovf", 128'(overflow), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pw_requant_writeback.md
# pw_requant_writeback

Downstream stage of the 32x16 pointwise scheduler. It consumes the scheduler's `y_valid` / `y_data` / `y_tile_sel` pulses, each carrying 16 lanes of signed 32-bit partial sums. Each lane is requantised to int8 with rounding shift, zero-point add, optional ReLU and saturation. The 16 bytes are packed into one 128-bit word and written to the feature buffer through a ready/valid write port with backpressure. A 2-entry input FIFO absorbs bursts, because the scheduler has no ready input.

## Interface
Parameters:
- `NUM_COLS`, 16: lanes per result word
- `ACC_BITS`, 32: signed accumulator width per lane
- `OUT_BITS`, 8: output lane width; `NUM_COLS*OUT_BITS` = 128
- `ADDR_W`, 16: feature buffer write address width

Ports:
- `CLK` in 1: single clock, rising edge
- `RESET` in 1: synchronous, active-high
- `start` in 1: one-cycle pulse; latches config, clears counters, flushes FIFO and pipeline
- `out_base` in ADDR_W: first write address
- `word_total` in 16: number of words expected in this run
- `shift_amt` in 5: right-shift, 0..31
- `zero_point` in 8: signed output offset
- `y_valid` in 1: result pulse
- `y_data` in NUM_COLS*ACC_BITS: lane i = bits [32i +: 32]
- `y_tile_sel` in 1: output bank select carried with data
- `feat_wr_en` out 1: write request
- `feat_wr_addr` out ADDR_W: write address
- `feat_wr_data` out 128: packed bytes, lane i = bits [8i +: 8]
- `feat_wr_bank` out 1: `y_tile_sel` of this word
- `feat_wr_ready` in 1: sink accepts
- `busy` out 1: high from `start` until `done`
- `done` out 1: one-cycle pulse
- `overflow` out 1: sticky, set when a `y_valid` is dropped

## Operation
- Config (`out_base`, `word_total`, `shift_amt`, `zero_point`) is latched on `start`. Inputs are ignored otherwise.
- `y_valid` pulses arriving while not `busy` are ignored.
- Pipeline:
  - FIFO (depth 2) holds `{y_data, y_tile_sel}`.
  - S1 register: round+shift.
  - S2/output register: zero-point, ReLU, saturate, pack.
- Per lane, on signed 32-bit `acc`:
  - If `shift_amt`==0: v = acc.
  - Otherwise: v = (acc + 2^(shift_amt-1)) >>> shift_amt, computed in 33 bits (arithmetic shift, round-half-up).
  - If PW_WB_RELU_EN is defined: v = max(v, 0).
  - w = v + sign-extended `zero_point`, in 34 bits.
  - Output byte = saturate(w, -128, 127).
- Write address = `out_base` + word_idx, modulo 2^ADDR_W (wraps silently). word_idx increments on each transfer.
- A transfer occurs when `feat_wr_en` && `feat_wr_ready`.
- The output register holds `feat_wr_data`, `feat_wr_addr` and `feat_wr_bank` stable while `feat_wr_en` is high and `feat_wr_ready` is low.
- S1 advances only when the output register is empty or transferring.
- The FIFO pops into S1 only when S1 is empty or advancing.
- Push to a full FIFO in the same cycle as a pop is accepted. Push to a full FIFO without a pop is dropped and sets `overflow`.
- `done` pulses the cycle after the transfer that makes word_idx == `word_total`; `busy` drops with it. Later `y_valid` pulses are ignored.
- If `word_total`==0, `done` pulses the cycle after `start`.
- `start` while `busy` aborts the current run:
  - Flushes the FIFO, S1 and the output register, dropping `feat_wr_en`.
  - Clears word_idx and `overflow`.
  - Latches new config.

## Timing
- Reset values:
  - Outputs `feat_wr_en`, `busy`, `done`, `overflow`, `feat_wr_bank`: 0.
  - Outputs `feat_wr_addr`, `feat_wr_data`: 0.
  - Internal FIFO: empty.
  - Internal valids: 0.
- `RESET` mid-run clears everything on the next edge. No write completes after it.
- Latency with an empty pipeline and `feat_wr_ready`=1: `y_valid` high in cycle N → FIFO write at end of N → S1 at end of N+1 → output register at end of N+2 → `feat_wr_en` high in N+3.
- Throughput: one word per cycle sustained.
- Capacity under a stalled sink: 4 words (output register + S1 + 2 FIFO entries).

## Configuration
- `PW_WB_RELU_EN` defined: negative post-shift values clamp to 0 before the zero-point add.
- `PW_WB_RELU_EN` undefined: no clamp; the full signed range is saturated to [-128, 127].

## Test plan
- Passthrough and saturation: `shift_amt`=0, `zero_point`=0, ReLU off, lanes 0..3 = 5, -3, 200, -200 → bytes 0x05, 0xFD, 0x7F, 0x80; `feat_wr_en` high exactly 3 cycles after `y_valid`.
- Rounding and zero-point: `shift_amt`=4, `zero_point`=+10, lanes 24, -24, 8, -9 → bytes 12, 9, 11, 9. Intermediate values v are 2, -1, 1, -1.
- ReLU build: PW_WB_RELU_EN defined, `shift_amt`=0, `zero_point`=-5, lanes -3, 7 → bytes 0xFB (-5), 0x02.
- Backpressure and overflow:
  - `feat_wr_ready`=0 and 6 back-to-back `y_valid` pulses → pulses 1-4 accepted, 5-6 dropped, `overflow`=1.
  - While stalled, `feat_wr_data`/`feat_wr_addr` stay stable.
  - After `feat_wr_ready`=1, exactly 4 transfers occur with data from pulses 1-4.
- Addressing and done: `out_base`=0xFFFF, `word_total`=3, 3 pulses with `y_tile_sel`=1,0,1 → addresses 0xFFFF, 0x0000, 0x0001; banks 1, 0, 1; `done` pulses one cycle after the third transfer; `busy` falls with it.
- Reset/restart mid-run: `RESET` with 2 words pending → all outputs 0 next cycle and no further writes. Separately, `start` with 2 words pending and `word_total`=0 → pipeline flushed, `done` pulses the following cycle.
